cga_idbctl_seln_reg: RTL and testbench

CGA_IDBCTL_SELN_REG -- requirements
Module: cga_idbctl_seln_reg

---
 rtl/cga_idbctl_seln_reg.sv | 101 ++++++++++
 tb/tb_cga_idbctl_seln_reg.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_idbctl_seln_reg.sv
// Input data bus selector: combines or prioritises N enabled source channels onto a
// registered bus and keeps sticky/counted records of loads that saw more than one enable.
module cga_idbctl_seln_reg #(
   parameter int N    = 6,
   parameter int W    = 16,
   parameter int MODE = 0
) (
   input  logic           sysclk,
   input  logic           sys_rst_n,
   input  logic [N*W-1:0] src_data,
   input  logic [N-1:0]   e_pins,
   input  logic           load,
   input  logic           err_clr,
   output logic [W-1:0]   idb_q,
   output logic           idb_valid,
   output logic [3:0]     sel_idx,
   output logic           mult_err,
   output logic [7:0]     err_cnt
);

   if (N < 2 || N > 16) begin : g_badN
      $error("cga_idbctl_seln_reg: N must be in 2..16");
   end
   if (W < 1 || W > 32) begin : g_badW
      $error("cga_idbctl_seln_reg: W must be in 1..32");
   end
   if (MODE != 0 && MODE != 1) begin : g_badMode
      $error("cga_idbctl_seln_reg: MODE must be 0 or 1");
   end

   logic [W-1:0] w_orSel;
   logic [W-1:0] w_prioSel;
   logic [W-1:0] w_sel;
   logic [3:0]   w_lowIdx;
   logic [4:0]   w_popCnt;
   logic         w_multi;

   logic [W-1:0] r_idbQ;
   logic         r_idbValid;
   logic [3:0]   r_selIdx;
   logic         r_multErr;
   logic [7:0]   r_errCnt;

   // Walking from the top index down lets the lowest enabled channel overwrite last.
   always_comb begin
      w_orSel   = '0;
      w_prioSel = '0;
      w_lowIdx  = 4'hF;
      w_popCnt  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (e_pins[k]) begin
            w_orSel   = w_orSel | src_data[k*W +: W];
            w_prioSel = src_data[k*W +: W];
            w_lowIdx  = 4'(k);
            w_popCnt  = w_popCnt + 5'd1;
         end
      end
   end

   assign w_sel   = (MODE == 1) ? w_prioSel : w_orSel;
   assign w_multi = (w_popCnt >= 5'd2);

   always_ff @(posedge sysclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_idbQ     <= '0;
         r_idbValid <= 1'b0;
         r_selIdx   <= 4'hF;
      end else begin
         r_idbValid <= load;
         if (load) begin
            r_idbQ   <= w_sel;
            r_selIdx <= w_lowIdx;
         end
      end
   end

   // A fresh multi-enable event outranks a simultaneous clear, restarting the count at 1.
   always_ff @(posedge sysclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_multErr <= 1'b0;
         r_errCnt  <= 8'd0;
      end else if (load && w_multi) begin
         r_multErr <= 1'b1;
         if (err_clr) begin
            r_errCnt <= 8'd1;
         end else if (r_errCnt != 8'hFF) begin
            r_errCnt <= r_errCnt + 8'd1;
         end
      end else if (err_clr) begin
         r_multErr <= 1'b0;
         r_errCnt  <= 8'd0;
      end
   end

   assign idb_q     = r_idbQ;
   assign idb_valid = r_idbValid;
   assign sel_idx   = r_selIdx;
   assign mult_err  = r_multErr;
   assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_cga_idbctl_seln_reg.sv
// Bench for cga_idbctl_seln_reg: one wired-OR and one priority instance share stimulus;
// directed scenarios plus a randomized run against a behavioural model.
module tb_cga_idbctl_seln_reg;

   localparam int N = 6;
   localparam int W = 16;

   logic           sysclk = 1'b0;
   logic           sys_rst_n = 1'b0;
   logic [N*W-1:0] src_data = '0;
   logic [N-1:0]   e_pins = '0;
   logic           load = 1'b0;
   logic           err_clr = 1'b0;

   logic [W-1:0] q0, q1;
   logic         v0, v1;
   logic [3:0]   idx0, idx1;
   logic         me0, me1;
   logic [7:0]   ec0, ec1;

   int nPass = 0;
   int nTotal = 0;

   cga_idbctl_seln_reg #(.N(N), .W(W), .MODE(0)) dut0 (
      .sysclk(sysclk), .sys_rst_n(sys_rst_n), .src_data(src_data), .e_pins(e_pins),
      .load(load), .err_clr(err_clr), .idb_q(q0), .idb_valid(v0), .sel_idx(idx0),
      .mult_err(me0), .err_cnt(ec0));

   cga_idbctl_seln_reg #(.N(N), .W(W), .MODE(1)) dut1 (
      .sysclk(sysclk), .sys_rst_n(sys_rst_n), .src_data(src_data), .e_pins(e_pins),
      .load(load), .err_clr(err_clr), .idb_q(q1), .idb_valid(v1), .sel_idx(idx1),
      .mult_err(me1), .err_cnt(ec1));

   always #5 sysclk = ~sysclk;

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      load = 1'b0;
      err_clr = 1'b0;
      tick();
      nTotal++;
      if ({q0, v0, idx0, me0, ec0} !== {16'h0, 1'b0, 4'hF, 1'b0, 8'h00})
         $display("[TB] FAIL reset_mode0: got %h required %h", {q0, v0, idx0, me0, ec0},
                  {16'h0, 1'b0, 4'hF, 1'b0, 8'h00});
      else nPass++;
      nTotal++;
      if ({q1, v1, idx1, me1, ec1} !== {16'h0, 1'b0, 4'hF, 1'b0, 8'h00})
         $display("[TB] FAIL reset_mode1: got %h required %h", {q1, v1, idx1, me1, ec1},
                  {16'h0, 1'b0, 4'hF, 1'b0, 8'h00});
      else nPass++;
      #3 sys_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_enable();
      src_data = '0;
      src_data[2*W +: W] = 16'h1234;
      src_data[4*W +: W] = 16'hFFFF;
      e_pins = 6'b000100;
      load = 1'b1;
      tick();
      load = 1'b0;
      nTotal++;
      if ({q0, v0, idx0, me0} !== {16'h1234, 1'b1, 4'd2, 1'b0})
         $display("[TB] FAIL single_enable_mode0: got %h required %h", {q0, v0, idx0, me0},
                  {16'h1234, 1'b1, 4'd2, 1'b0});
      else nPass++;
      nTotal++;
      if ({q1, v1, idx1, me1} !== {16'h1234, 1'b1, 4'd2, 1'b0})
         $display("[TB] FAIL single_enable_mode1: got %h required %h", {q1, v1, idx1, me1},
                  {16'h1234, 1'b1, 4'd2, 1'b0});
      else nPass++;
      tick();
      nTotal++;
      if ({q0, v0} !== {16'h1234, 1'b0})
         $display("[TB] FAIL single_enable_pulse_end: got %h required %h", {q0, v0},
                  {16'h1234, 1'b0});
      else nPass++;
   endtask

   task automatic test_conflict();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      src_data = '0;
      src_data[0*W +: W] = 16'h00F0;
      src_data[5*W +: W] = 16'h0F00;
      e_pins = 6'b100001;
      load = 1'b1;
      tick();
      load = 1'b0;
      nTotal++;
      if ({q0, idx0, me0, ec0} !== {16'h0FF0, 4'd0, 1'b1, 8'd1})
         $display("[TB] FAIL wired_or_conflict: got %h required %h", {q0, idx0, me0, ec0},
                  {16'h0FF0, 4'd0, 1'b1, 8'd1});
      else nPass++;
      nTotal++;
      if ({q1, idx1, me1, ec1} !== {16'h00F0, 4'd0, 1'b1, 8'd1})
         $display("[TB] FAIL priority_conflict: got %h required %h", {q1, idx1, me1, ec1},
                  {16'h00F0, 4'd0, 1'b1, 8'd1});
      else nPass++;
      // single-enable load must leave the error state alone
      e_pins = 6'b010000;
      src_data[4*W +: W] = 16'hBEEF;
      load = 1'b1;
      tick();
      load = 1'b0;
      nTotal++;
      if ({q1, idx1, me1, ec1} !== {16'hBEEF, 4'd4, 1'b1, 8'd1})
         $display("[TB] FAIL single_keeps_err: got %h required %h", {q1, idx1, me1, ec1},
                  {16'hBEEF, 4'd4, 1'b1, 8'd1});
      else nPass++;
   endtask

   task automatic test_no_enable_hold();
      e_pins = '0;
      src_data = {N{16'hA5A5}};
      load = 1'b1;
      tick();
      load = 1'b0;
      nTotal++;
      if ({q0, idx0, q1, idx1} !== {16'h0, 4'hF, 16'h0, 4'hF})
         $display("[TB] FAIL no_enable: got %h required %h", {q0, idx0, q1, idx1},
                  {16'h0, 4'hF, 16'h0, 4'hF});
      else nPass++;
      for (int i = 0; i < 5; i++) begin
         src_data = {$urandom, $urandom, $urandom};
         e_pins = 6'($urandom);
         tick();
         nTotal++;
         if ({q0, v0, idx0, q1, v1} !== {16'h0, 1'b0, 4'hF, 16'h0, 1'b0})
            $display("[TB] FAIL hold_cycle%0d: got %h required %h", i,
                     {q0, v0, idx0, q1, v1}, {16'h0, 1'b0, 4'hF, 16'h0, 1'b0});
         else nPass++;
      end
   endtask

   task automatic test_back_to_back();
      load = 1'b1;
      for (int i = 0; i < 4; i++) begin
         src_data = '0;
         src_data[(i+1)*W +: W] = 16'(16'h1000 + i);
         e_pins = 6'(1 << (i + 1));
         tick();
         nTotal++;
         if ({q0, v0, idx0} !== {16'(16'h1000 + i), 1'b1, 4'(i + 1)})
            $display("[TB] FAIL back_to_back%0d: got %h required %h", i, {q0, v0, idx0},
                     {16'(16'h1000 + i), 1'b1, 4'(i + 1)});
         else nPass++;
      end
      load = 1'b0;
      tick();
   endtask

   task automatic test_saturation();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      e_pins = 6'b000011;
      load = 1'b1;
      for (int i = 0; i < 300; i++) tick();
      load = 1'b0;
      nTotal++;
      if ({me0, ec0, me1, ec1} !== {1'b1, 8'hFF, 1'b1, 8'hFF})
         $display("[TB] FAIL saturate: got %h required %h", {me0, ec0, me1, ec1},
                  {1'b1, 8'hFF, 1'b1, 8'hFF});
      else nPass++;
      err_clr = 1'b1;
      load = 1'b1;
      tick();
      load = 1'b0;
      nTotal++;
      if ({me0, ec0} !== {1'b1, 8'd1})
         $display("[TB] FAIL clr_with_event: got %h required %h", {me0, ec0}, {1'b1, 8'd1});
      else nPass++;
      tick();
      err_clr = 1'b0;
      nTotal++;
      if ({me0, ec0, me1, ec1} !== {1'b0, 8'd0, 1'b0, 8'd0})
         $display("[TB] FAIL clr_alone: got %h required %h", {me0, ec0, me1, ec1},
                  {1'b0, 8'd0, 1'b0, 8'd0});
      else nPass++;
   endtask

   task automatic test_async_reset();
      src_data = '0;
      src_data[3*W +: W] = 16'h5A5A;
      src_data[1*W +: W] = 16'h0101;
      e_pins = 6'b001010;
      load = 1'b1;
      tick();
      load = 1'b0;
      #2 sys_rst_n = 1'b0;
      #1;
      nTotal++;
      if ({q0, v0, idx0, me0, ec0} !== {16'h0, 1'b0, 4'hF, 1'b0, 8'h00})
         $display("[TB] FAIL async_reset: got %h required %h", {q0, v0, idx0, me0, ec0},
                  {16'h0, 1'b0, 4'hF, 1'b0, 8'h00});
      else nPass++;
      tick();
      #2 sys_rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         nTotal++;
         if ({v0, v1, q1} !== {1'b0, 1'b0, 16'h0})
            $display("[TB] FAIL no_residual_valid%0d: got %h required %h", i, {v0, v1, q1},
                     {1'b0, 1'b0, 16'h0});
         else nPass++;
      end
      // load present at the first edge after release must be honoured
      sys_rst_n = 1'b0;
      #2;
      src_data[2*W +: W] = 16'hABCD;
      e_pins = 6'b000100;
      load = 1'b1;
      sys_rst_n = 1'b1;
      tick();
      load = 1'b0;
      nTotal++;
      if ({q0, v0, idx0} !== {16'hABCD, 1'b1, 4'd2})
         $display("[TB] FAIL load_at_release: got %h required %h", {q0, v0, idx0},
                  {16'hABCD, 1'b1, 4'd2});
      else nPass++;
   endtask

   task automatic test_random();
      logic [W-1:0] eQ0, eQ1, orv, ch;
      logic [3:0]   eIdx;
      logic         eValid, eErr;
      logic [7:0]   eCnt;
      logic [N-1:0] oneHot;
      int           lowest;
      err_clr = 1'b1;
      load = 1'b0;
      tick();
      err_clr = 1'b0;
      eQ0 = q0; eQ1 = q1; eIdx = idx0;
      eQ0 = 16'hABCD; eQ1 = 16'hABCD; eIdx = 4'd2;
      eValid = 1'b0; eErr = 1'b0; eCnt = 8'd0;
      for (int i = 0; i < 400; i++) begin
         src_data = {$urandom, $urandom, $urandom};
         if ($urandom_range(0, 2) == 0) e_pins = 6'(1 << $urandom_range(0, N - 1));
         else e_pins = 6'($urandom);
         load = ($urandom_range(0, 3) != 0);
         err_clr = ($urandom_range(0, 7) == 0);
         orv = '0;
         for (int k = 0; k < N; k++)
            if (e_pins[k]) orv |= 16'(src_data >> (k * W));
         oneHot = e_pins & (~e_pins + 6'd1);
         lowest = $clog2(oneHot);
         ch = (e_pins == 0) ? 16'h0 : 16'(src_data >> (lowest * W));
         eValid = load;
         if (load) begin
            eQ0 = orv;
            eQ1 = ch;
            eIdx = (e_pins == 0) ? 4'hF : 4'(lowest);
         end
         if (load && $countones(e_pins) >= 2) begin
            eErr = 1'b1;
            eCnt = err_clr ? 8'd1 : ((eCnt == 8'hFF) ? 8'hFF : eCnt + 8'd1);
         end else if (err_clr) begin
            eErr = 1'b0;
            eCnt = 8'd0;
         end
         tick();
         nTotal++;
         if ({q0, v0, idx0, me0, ec0} !== {eQ0, eValid, eIdx, eErr, eCnt})
            $display("[TB] FAIL random_mode0 #%0d: got %h required %h", i,
                     {q0, v0, idx0, me0, ec0}, {eQ0, eValid, eIdx, eErr, eCnt});
         else nPass++;
         nTotal++;
         if ({q1, v1, idx1, me1, ec1} !== {eQ1, eValid, eIdx, eErr, eCnt})
            $display("[TB] FAIL random_mode1 #%0d: got %h required %h", i,
                     {q1, v1, idx1, me1, ec1}, {eQ1, eValid, eIdx, eErr, eCnt});
         else nPass++;
      end
      load = 1'b0;
      err_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_enable();
      test_conflict();
      test_no_enable_hold();
      test_back_to_back();
      test_saturation();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule
